memoria_dados: RTL and testbench
================================

MEMORIA_DADOS -- requirements
Module: memoria_dados

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 6, meaning log2 of the number of 32-bit words stored (64 words).
REQ-002 The block SHALL have parameter LATENCIA, default 2, range 0..7, meaning wait cycles inserted between request acceptance and response.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req  input  1  access request from the control unit.
REQ-006 we  input  1  1 = store, 0 = load.
REQ-007 funct3  input  3  access size/sign: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  store data, right-aligned.
REQ-010 rdata  output  32  load result, extended to 32 bits.
REQ-011 ack  output  1  one-cycle response strobe.
REQ-012 err  output  1  access fault, valid when ack=1.
REQ-013 busy  output  1  request in flight; new requests ignored.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, RESP; busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-015 In IDLE, req=1 at a rising edge SHALL latch we, funct3, addr, wdata and transition to WAIT with the wait counter at 0 if LATENCIA>0, else directly to RESP.
REQ-016 In WAIT, the counter SHALL increment each cycle; at the edge where it reaches LATENCIA-1, the FSM SHALL transition to RESP.
REQ-017 The memory access (read or write) SHALL occur on the edge entering RESP, using only the latched request fields.
REQ-018 ack SHALL be 1 for exactly the one cycle spent in RESP; a request accepted at edge k SHALL produce ack=1 in the cycle after edge k+LATENCIA.
REQ-019 RESP SHALL always return to IDLE on the next edge; the earliest next request SHALL be sampled on the edge after ack falls.
REQ-020 req, we, funct3, addr, wdata SHALL be ignored while busy=1.
REQ-021 Word index SHALL be addr[DEPTH_LOG2+1:2]; byte lane SHALL be addr[1:0].
REQ-022 Stores SHALL write only the addressed lanes: byte writes wdata[7:0] to lane addr[1:0]; half writes wdata[15:0] to lanes addr[1]*2..+1; word writes all 4 lanes.
REQ-023 Loads SHALL extract the addressed byte/half/word and sign-extend (000, 001) or zero-extend (100, 101).
REQ-024 err SHALL be 1 in RESP when any holds: half access with addr[0]=1; word access with addr[1:0]!=00; addr[31:DEPTH_LOG2+2]!=0; funct3 in {011,110,111}; store with funct3[2]=1.
REQ-025 On err=1, no memory write SHALL occur and rdata SHALL be 0.
REQ-026 On a store response, rdata SHALL be 0; rdata SHALL hold its value outside RESP until the next response.
REQ-027 Store-then-load to the same word SHALL return the newly written data (no stale read).

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, ack=0, err=0, busy=0, rdata=0, independent of clk.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the transaction: no write if not yet performed, and no ack after reset release.
REQ-030 Memory contents SHALL NOT be cleared by reset; contents written before reset SHALL remain readable after.

Verification
REQ-031 LATENCIA=2: store word addr=0x10, wdata=0xDEADBEEF at edge k -> busy=1 at edges k+1..k+2, ack=1 and err=0 in cycle after edge k+2; load word addr=0x10 -> rdata=0xDEADBEEF.
REQ-032 After REQ-031: store byte addr=0x11, wdata=0x80 -> load word 0x10 returns 0xDEAD80EF; load byte 0x11 returns 0xFFFFFF80; load byte unsigned returns 0x00000080.
REQ-033 Load half addr=0x13 -> ack=1, err=1, rdata=0; store word addr=0x102 -> err=1, word 0x100 unchanged; store with funct3=100 -> err=1.
REQ-034 Second req held high during busy with addr=0x20 -> ignored; only one ack per accepted request; back-to-back requests -> one ack every LATENCIA+2 cycles.
REQ-035 rst pulsed mid-WAIT of a store to 0x30 -> outputs 0 immediately, no ack, subsequent load of 0x30 returns the prior contents.
REQ-036 LATENCIA=0: request at edge k -> ack=1 in cycle after edge k, busy=1 for that cycle only.

Source files
------------

// File: rtl/memoria_dados.sv
// Data memory with a request/acknowledge handshake, a configurable number of wait
// cycles, byte/half/word accesses with sign or zero extension, and access-fault detection.
module memoria_dados #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCIA   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack,
    output logic        err,
    output logic        busy
);

    localparam int WORDS = 1 << DEPTH_LOG2;
    localparam logic [2:0] LAST = 3'((LATENCIA > 0) ? LATENCIA - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [WORDS];

    logic                  go_resp;
    logic                  a_we;
    logic [2:0]            a_f3;
    logic [31:0]           a_addr;
    logic [31:0]           a_wdata;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            lane;
    logic                  fault;
    logic [31:0]           word;
    logic [31:0]           lane_word;
    logic [31:0]           load_val;
    logic [3:0]            be;
    logic [31:0]           wdata_sh;

    // With zero latency the accept edge is also the access edge, so the live inputs
    // (which are being latched on that same edge) stand in for the latched fields.
    always_comb begin
        go_resp = 1'b0;
        if (state == IDLE)
            go_resp = req && (LATENCIA == 0);
        else if (state == WAIT)
            go_resp = (cnt == LAST);

        a_we    = (state == IDLE) ? we     : we_q;
        a_f3    = (state == IDLE) ? funct3 : f3_q;
        a_addr  = (state == IDLE) ? addr   : addr_q;
        a_wdata = (state == IDLE) ? wdata  : wdata_q;

        idx  = a_addr[DEPTH_LOG2+1:2];
        lane = a_addr[1:0];

        case (a_f3)
            3'b000, 3'b100: fault = 1'b0;
            3'b001, 3'b101: fault = a_addr[0];
            3'b010:         fault = |a_addr[1:0];
            default:        fault = 1'b1;
        endcase
        if ((a_addr >> (DEPTH_LOG2 + 2)) != 32'd0)
            fault = 1'b1;
        if (a_we && a_f3[2])
            fault = 1'b1;

        word      = mem[idx];
        lane_word = word >> {lane, 3'b000};
        case (a_f3[1:0])
            2'b00:   load_val = a_f3[2] ? {24'd0, lane_word[7:0]}
                                        : {{24{lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_val = a_f3[2] ? {16'd0, lane_word[15:0]}
                                        : {{16{lane_word[15]}}, lane_word[15:0]};
            default: load_val = lane_word;
        endcase

        case (a_f3[1:0])
            2'b00: begin
                be       = 4'b0001 << lane;
                wdata_sh = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {lane[1], 1'b0};
                wdata_sh = {2{a_wdata[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wdata_sh = a_wdata;
            end
        endcase
    end

    // Storage is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && a_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rdata   <= 32'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        f3_q    <= funct3;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= 3'd0;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end
                WAIT: cnt <= cnt + 3'd1;
                RESP: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (go_resp) begin
                state <= RESP;
                ack   <= 1'b1;
                err   <= fault;
                rdata <= (fault || a_we) ? 32'd0 : load_val;
            end
        end
    end

endmodule

// File: tb/tb_memoria_dados.sv
// Directed bench for memoria_dados: a table of accesses against the default-latency
// instance, hand-written handshake/reset corner cases, and a zero-latency instance.
module tb_memoria_dados;

    logic        clk;
    logic        rst;
    logic        req, we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata, rdata;
    logic        ack, err, busy;

    logic        z_req, z_we;
    logic [2:0]  z_funct3;
    logic [31:0] z_addr, z_wdata, z_rdata;
    logic        z_ack, z_err, z_busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t tbl[$];

    memoria_dados #(.DEPTH_LOG2(6), .LATENCIA(2)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr),
        .wdata(wdata), .rdata(rdata), .ack(ack), .err(err), .busy(busy)
    );

    memoria_dados #(.DEPTH_LOG2(6), .LATENCIA(0)) dut0 (
        .clk(clk), .rst(rst), .req(z_req), .we(z_we), .funct3(z_funct3), .addr(z_addr),
        .wdata(z_wdata), .rdata(z_rdata), .ack(z_ack), .err(z_err), .busy(z_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] r, input logic e);
        vec_t v;
        v.we = w; v.f3 = f; v.addr = a; v.wdata = d; v.exp_rdata = r; v.exp_err = e;
        return v;
    endfunction

    // One full transaction on the LATENCIA=2 instance; returns the response and latency.
    task automatic applyStimulus(input logic w, input logic [2:0] f, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] rd,
                                 output logic e, output int lat);
        logic busy_ok;
        @(negedge clk);
        req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; we = ~w; funct3 = 3'b111; addr = 32'hFFFF_FFFF; wdata = ~d;
        lat = 1;
        busy_ok = 1'b1;
        while (!ack && lat < 20) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        checkOutput("ack arrives", {31'd0, ack}, 32'd1);
        checkOutput("busy while pending", {31'd0, busy_ok}, 32'd1);
        checkOutput("busy during ack", {31'd0, busy}, 32'd1);
        rd = rdata;
        e  = err;
        @(negedge clk);
        checkOutput("ack one cycle", {31'd0, ack}, 32'd0);
        checkOutput("busy after resp", {31'd0, busy}, 32'd0);
        checkOutput("rdata holds", rdata, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          n;
        int          ack_cnt;
        int          ack_pos[3];

        rst = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
        z_req = 1'b0; z_we = 1'b0; z_funct3 = 3'd0; z_addr = 32'd0; z_wdata = 32'd0;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset ack", {31'd0, ack}, 32'd0);
        checkOutput("reset err", {31'd0, err}, 32'd0);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset rdata", rdata, 32'd0);
        checkOutput("reset busy lat0", {31'd0, z_busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back(mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0));
        tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0));
        tbl.push_back(mk(1, 3'b000, 32'h11,  32'h00000080, 32'h0,        0));
        tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 0));
        tbl.push_back(mk(0, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 0));
        tbl.push_back(mk(0, 3'b100, 32'h11,  32'h0,        32'h00000080, 0));
        tbl.push_back(mk(0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 0));
        tbl.push_back(mk(0, 3'b101, 32'h12,  32'h0,        32'h0000DEAD, 0));
        tbl.push_back(mk(0, 3'b001, 32'h10,  32'h0,        32'hFFFF80EF, 0));
        tbl.push_back(mk(0, 3'b001, 32'h13,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 3'b000, 32'h10,  32'h0,        32'hFFFFFFEF, 0));
        tbl.push_back(mk(1, 3'b010, 32'h00,  32'h11223344, 32'h0,        0));
        tbl.push_back(mk(1, 3'b010, 32'h20,  32'hA5A5A5A5, 32'h0,        0));
        tbl.push_back(mk(1, 3'b010, 32'h100, 32'h77777777, 32'h0,        1));
        tbl.push_back(mk(0, 3'b010, 32'h00,  32'h0,        32'h11223344, 0));
        tbl.push_back(mk(1, 3'b010, 32'h102, 32'h66666666, 32'h0,        1));
        tbl.push_back(mk(1, 3'b010, 32'h22,  32'h55555555, 32'h0,        1));
        tbl.push_back(mk(0, 3'b010, 32'h20,  32'h0,        32'hA5A5A5A5, 0));
        tbl.push_back(mk(1, 3'b100, 32'h10,  32'h000000AA, 32'h0,        1));
        tbl.push_back(mk(1, 3'b101, 32'h10,  32'h0000BBBB, 32'h0,        1));
        tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 0));
        tbl.push_back(mk(0, 3'b011, 32'h10,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 3'b110, 32'h10,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 3'b010, 32'h100, 32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 3'b001, 32'h12,  32'h1234CAFE, 32'h0,        0));
        tbl.push_back(mk(1, 3'b000, 32'h13,  32'hFFFFFF01, 32'h0,        0));
        tbl.push_back(mk(0, 3'b010, 32'h10,  32'h0,        32'h01FE80EF, 0));
        tbl.push_back(mk(0, 3'b001, 32'h11,  32'h0,        32'h0,        1));
        tbl.push_back(mk(0, 3'b010, 32'h12,  32'h0,        32'h0,        1));
        tbl.push_back(mk(1, 3'b010, 32'h30,  32'h0BADF00D, 32'h0,        0));
        tbl.push_back(mk(0, 3'b100, 32'h13,  32'h0,        32'h00000001, 0));
        tbl.push_back(mk(0, 3'b001, 32'h12,  32'h0,        32'h000001FE, 0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, rd, e, lat);
            checkOutput($sformatf("vec%0d rdata", i), rd, tbl[i].exp_rdata);
            checkOutput($sformatf("vec%0d err", i), {31'd0, e}, {31'd0, tbl[i].exp_err});
            checkOutput($sformatf("vec%0d latency", i), lat, 32'd3);
        end

        // Request held high while busy, with the fields switched to a store at 0x20.
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10; wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);
        we = 1'b1; addr = 32'h20; wdata = 32'h99999999;
        n = 1;
        while (!ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("held req ack", {31'd0, ack}, 32'd1);
        checkOutput("held req rdata", rdata, 32'h01FE80EF);
        req = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) ack_cnt++;
        end
        checkOutput("held req no extra ack", ack_cnt, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
        checkOutput("held req 0x20 untouched", rd, 32'hA5A5A5A5);

        // Back-to-back requests: one ack every LATENCIA+2 cycles.
        @(negedge clk);
        req = 1'b1; we = 1'b0; funct3 = 3'b010; addr = 32'h10;
        ack_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (ack) begin
                if (ack_cnt < 3) ack_pos[ack_cnt] = i;
                ack_cnt++;
            end
            if (i == 11) req = 1'b0;
        end
        checkOutput("b2b ack count", ack_cnt, 32'd3);
        if (ack_cnt == 3) begin
            checkOutput("b2b first ack", ack_pos[0], 32'd3);
            checkOutput("b2b gap1", ack_pos[1] - ack_pos[0], 32'd4);
            checkOutput("b2b gap2", ack_pos[2] - ack_pos[1], 32'd4);
        end

        // Reset in the middle of WAIT of a store to 0x30.
        applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        checkOutput("pre-abort load", rd, 32'h0BADF00D);
        @(negedge clk);
        req = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h30; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        checkOutput("abort busy before rst", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort busy", {31'd0, busy}, 32'd0);
        checkOutput("abort ack", {31'd0, ack}, 32'd0);
        checkOutput("abort err", {31'd0, err}, 32'd0);
        checkOutput("abort rdata", rdata, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ack_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) ack_cnt++;
        end
        checkOutput("abort no ack", ack_cnt, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        checkOutput("abort 0x30 kept", rd, 32'h0BADF00D);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, e, lat);
        checkOutput("mem survives reset", rd, 32'h01FE80EF);

        // Zero-latency instance: ack in the cycle right after the accept edge.
        @(negedge clk);
        z_req = 1'b1; z_we = 1'b1; z_funct3 = 3'b010; z_addr = 32'h4; z_wdata = 32'hCAFEBABE;
        @(posedge clk);
        @(negedge clk);
        z_req = 1'b0; z_addr = 32'h0; z_wdata = 32'h0;
        checkOutput("lat0 store ack", {31'd0, z_ack}, 32'd1);
        checkOutput("lat0 store busy", {31'd0, z_busy}, 32'd1);
        checkOutput("lat0 store err", {31'd0, z_err}, 32'd0);
        @(negedge clk);
        checkOutput("lat0 ack drops", {31'd0, z_ack}, 32'd0);
        checkOutput("lat0 busy drops", {31'd0, z_busy}, 32'd0);
        z_req = 1'b1; z_we = 1'b0; z_addr = 32'h4;
        @(posedge clk);
        @(negedge clk);
        z_req = 1'b0; z_addr = 32'h0;
        checkOutput("lat0 load ack", {31'd0, z_ack}, 32'd1);
        checkOutput("lat0 load rdata", z_rdata, 32'hCAFEBABE);
        @(negedge clk);
        z_req = 1'b1; z_we = 1'b0; z_funct3 = 3'b010; z_addr = 32'h6;
        @(posedge clk);
        @(negedge clk);
        z_req = 1'b0;
        checkOutput("lat0 misaligned err", {31'd0, z_err}, 32'd1);
        checkOutput("lat0 misaligned rdata", z_rdata, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
